crossy_lane_engine: RTL and testbench
=====================================

Name: crossy_lane_engine

Overview:
- Parametrised game core for the VGA crossy-road game, with N obstacle lanes instead of a fixed three.
- Adds per-lane direction, score-based speed levels, tear-free hop scrolling on frame boundaries, a latched collision, and an IDLE/PLAY/DEAD state machine with a flashing death screen and auto-restart.
- Sits between the VGA timing generator (pixel coordinates, frame tick) and the top-level RGB mux. Score text overlay stays external, driven by the score output.

Parameters:
- N_LANES, 3, obstacle lane count (1..8)
- SCREEN_W, 640, visible width in px
- SCREEN_H, 480, visible height in px
- OB_W, 120, obstacle width
- OB_H, 70, obstacle height
- LANE_PITCH, 160, vertical lane spacing
- OB_X_SPACING, 200, reset x stagger between lanes
- HOP_PX, 16, vertical scroll per hop
- CHICKEN_X, 310, chicken left edge
- CHICKEN_Y, 420, chicken top edge
- CHICKEN_W, 30, chicken width
- CHICKEN_H, 40, chicken height
- BASE_SPEED, 1, px/frame at level 0
- DEAD_FRAMES, 60, frames spent in DEAD
- SCORE_MAX, 99, score saturation value

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse, once per frame, during vertical blank
- move_btn  in  1  debounced button level
- video_on  in  1  visible-area flag
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan row
- rgb  out  3  registered pixel colour: {B,G,R}
- score  out  7  hops survived
- game_state  out  2  00 IDLE, 01 PLAY, 10 DEAD
- collision  out  1  one-cycle pulse when PLAY enters DEAD

Behaviour:
- Reset and state:
  - One clock; reset is synchronous, active-low, named rst_n; all flops clear on a clk edge with rst_n=0.
  - Reset values: rgb=000, score=0, game_state=IDLE, collision=0, y_offset=0.
  - Lane x positions reset to x[i]=(i*OB_X_SPACING) mod WRAP.
  - Derived constants: WRAP=SCREEN_W+OB_W, SPAN=N_LANES*LANE_PITCH.
- Button handling:
  - move_btn is registered once.
  - A rising edge (cur=1, prev=0) forms btn_rise; holding the button yields one event only.
- Horizontal motion:
  - Position x[i] is in [0,WRAP). Lane i covers columns x[i]-OB_W <= px < x[i].
  - Compare as px < x[i] && px+OB_W >= x[i] at 11 bits; no negative values.
  - Updates only on frame_tick in PLAY.
  - Even lanes move right: x = x+spd, minus WRAP if the result is >= WRAP.
  - Odd lanes move left: x = x-spd, plus WRAP if the result is < 0.
  - spd = BASE_SPEED + score[6:4]; checked at 11 bits.
- Vertical motion:
  - Lane top row is ly[i]=(i*LANE_PITCH + y_offset) mod SPAN.
  - Lane i is drawn only if ly[i] < SCREEN_H and ly[i] <= py < ly[i]+OB_H.
  - A btn_rise in PLAY sets hop_pend.
  - On the next frame_tick: y_offset=(y_offset+HOP_PX) mod SPAN, hop_pend clears, and score increments, saturating at SCORE_MAX.
  - Multiple btn_rise events within one frame count as one hop.
- Hit test:
  - ob_hit = OR over lanes of the horizontal and vertical hits.
  - ch_hit = scan position inside the chicken box.
  - hit_latch sets when video_on && ob_hit && ch_hit in PLAY; clears on the next frame_tick.
- State machine:
  - IDLE: positions frozen, no scoring. btn_rise moves to PLAY next cycle; that edge is not a hop.
  - PLAY, frame_tick with hit_latch=1: go to DEAD, pulse collision for that cycle, clear death counter, discard hop_pend (collision beats hop in the same frame; score unchanged).
  - DEAD: positions frozen, btn ignored, counter increments per frame_tick. Chicken is visible when counter[3]=0.
  - DEAD exit: the frame_tick where counter == DEAD_FRAMES-1 moves to IDLE and applies the reset values except game_state=IDLE (score=0, y_offset=0, x stagger).
  - rst_n=0 mid-game returns to reset values regardless of state.
- Render (one-cycle latency):
  - rgb at cycle n+1 reflects pixel_x/pixel_y/video_on at cycle n.
  - Priority, highest first:
    - !video_on gives 000.
    - Obstacle gives 001 (red).
    - Chicken, when visible, gives 010 (green).
    - Otherwise background 100 (blue).
  - In IDLE the chicken is always visible.
  - Hit detection uses the unregistered compare, same cycle as the pixel inputs.

Test Plan:
- Reset/idle: rst_n=0 for 2 clocks, N_LANES=3. Expect rgb=000, score=0, game_state=00, x={0,200,400}. 10 frame_ticks without button leave x unchanged.
- Start/scroll: btn_rise, then 1 frame_tick. Expect game_state=01, score=0, lane0 x=1, lane1 x=199.
- Wrap: lane0 at x=759 with spd=1; frame_tick gives x=0. Lane1 at x=0 gives x=759.
- Hop: 3 btn_rise within one frame then frame_tick gives score=1, y_offset=16. With score=16, the next frame_tick moves lane0 by 2 px.
- Collision: place lane x/y to overlap (320,430) and scan with video_on=1, plus a pending hop. At frame_tick: collision=1 for one cycle, game_state=10, score unchanged. Chicken blank for frames 8-15. After 60 frame_ticks: game_state=00, score=0.
- Render/saturation: pixel (315,425) with no obstacle gives rgb=010 one cycle later; video_on=0 gives 000. 120 hops give score=99.

Source files
------------

// File: rtl/crossy_lane_engine.sv
`default_nettype none
// ============================================================================
// Module   : crossy_lane_engine
// Brief    : N-lane crossy-road game core: lane motion, hop scrolling,
//            collision latch, IDLE/PLAY/DEAD control and registered pixel colour.
// Revision : 1.0 - initial release
// ============================================================================
module crossy_lane_engine #(
    parameter int N_LANES      = 3,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int OB_W         = 120,
    parameter int OB_H         = 70,
    parameter int LANE_PITCH   = 160,
    parameter int OB_X_SPACING = 200,
    parameter int HOP_PX       = 16,
    parameter int CHICKEN_X    = 310,
    parameter int CHICKEN_Y    = 420,
    parameter int CHICKEN_W    = 30,
    parameter int CHICKEN_H    = 40,
    parameter int BASE_SPEED   = 1,
    parameter int DEAD_FRAMES  = 60,
    parameter int SCORE_MAX    = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_btn,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [2:0] rgb,
    output logic [6:0] score,
    output logic [1:0] game_state,
    output logic       collision
);

    localparam int c_wrap  = SCREEN_W + OB_W;
    localparam int c_span  = N_LANES * LANE_PITCH;
    localparam int c_cnt_w = ($clog2(DEAD_FRAMES) > 4) ? $clog2(DEAD_FRAMES) : 4;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEAD_FRAMES - 1);

    localparam logic [2:0] c_rgb_off     = 3'b000;
    localparam logic [2:0] c_rgb_red     = 3'b001;
    localparam logic [2:0] c_rgb_green   = 3'b010;
    localparam logic [2:0] c_rgb_blue    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    function automatic logic [10:0] f_x_init(input int idx);
        return 11'((idx * OB_X_SPACING) % c_wrap);
    endfunction

    state_t                      r_state;
    logic                        r_btn;
    logic                        r_btn_d;
    logic                        r_hop_pend;
    logic                        r_hit_latch;
    logic                        r_collision;
    logic [6:0]                  r_score;
    logic [11:0]                 r_y_offset;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [2:0]                  r_rgb;
    logic [N_LANES-1:0][10:0]    r_lane_x;

    logic                        w_btn_rise;
    logic [10:0]                 w_spd;
    logic [10:0]                 w_px;
    logic [11:0]                 w_py;
    logic [11:0]                 w_y_sum;
    logic [11:0]                 w_y_offset_hop;
    logic [N_LANES-1:0]          w_lane_hit;
    logic [N_LANES-1:0][10:0]    w_lane_x_next;
    logic                        w_ob_hit;
    logic                        w_ch_hit;
    logic                        w_chick_vis;
    logic                        w_hit_now;
    logic [2:0]                  w_rgb_next;

    assign w_btn_rise = r_btn & ~r_btn_d;
    assign w_spd      = 11'(BASE_SPEED) + {8'd0, r_score[6:4]};
    assign w_px       = {1'b0, pixel_x};
    assign w_py       = {2'b00, pixel_y};

    assign w_y_sum        = r_y_offset + 12'(HOP_PX);
    assign w_y_offset_hop = (w_y_sum >= 12'(c_span)) ? w_y_sum - 12'(c_span) : w_y_sum;

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [11:0] w_ly_sum;
            logic [11:0] w_ly;
            logic        w_h_hit;
            logic        w_v_hit;

            // Lane top row wraps modulo the full lane span, so lanes scroll off the
            // bottom and reappear above the visible area.
            assign w_ly_sum = 12'(gi * LANE_PITCH) + r_y_offset;
            assign w_ly     = (w_ly_sum >= 12'(c_span)) ? w_ly_sum - 12'(c_span) : w_ly_sum;

            // x marks the obstacle's right edge; the body trails OB_W pixels behind.
            assign w_h_hit = (w_px < r_lane_x[gi]) && ((w_px + 11'(OB_W)) >= r_lane_x[gi]);
            assign w_v_hit = (w_ly < 12'(SCREEN_H)) && (w_py >= w_ly) &&
                             (w_py < (w_ly + 12'(OB_H)));
            assign w_lane_hit[gi] = w_h_hit & w_v_hit;

            if ((gi % 2) == 0) begin : g_right
                logic [10:0] w_sum;
                assign w_sum = r_lane_x[gi] + w_spd;
                assign w_lane_x_next[gi] = (w_sum >= 11'(c_wrap)) ? w_sum - 11'(c_wrap) : w_sum;
            end else begin : g_left
                assign w_lane_x_next[gi] = (r_lane_x[gi] < w_spd) ?
                                           r_lane_x[gi] + 11'(c_wrap) - w_spd :
                                           r_lane_x[gi] - w_spd;
            end
        end
    endgenerate

    assign w_ob_hit = |w_lane_hit;
    assign w_ch_hit = (w_px >= 11'(CHICKEN_X)) && (w_px < 11'(CHICKEN_X + CHICKEN_W)) &&
                      (w_py >= 12'(CHICKEN_Y)) && (w_py < 12'(CHICKEN_Y + CHICKEN_H));

    // The death screen blinks the chicken with an 8-frame half period.
    assign w_chick_vis = (r_state != ST_DEAD) || !r_cnt[3];
    assign w_hit_now   = (r_state == ST_PLAY) && video_on && w_ob_hit && w_ch_hit;

    always_comb begin
        w_rgb_next = c_rgb_blue;
        if (!video_on) begin
            w_rgb_next = c_rgb_off;
        end else if (w_ob_hit) begin
            w_rgb_next = c_rgb_red;
        end else if (w_ch_hit && w_chick_vis) begin
            w_rgb_next = c_rgb_green;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_btn       <= 1'b0;
            r_btn_d     <= 1'b0;
            r_hop_pend  <= 1'b0;
            r_hit_latch <= 1'b0;
            r_collision <= 1'b0;
            r_score     <= 7'd0;
            r_y_offset  <= 12'd0;
            r_cnt       <= '0;
            r_rgb       <= c_rgb_off;
            for (int i = 0; i < N_LANES; i++) begin
                r_lane_x[i] <= f_x_init(i);
            end
        end else begin
            r_btn       <= move_btn;
            r_btn_d     <= r_btn;
            r_collision <= 1'b0;
            r_rgb       <= w_rgb_next;

            if (frame_tick) begin
                r_hit_latch <= 1'b0;
            end else if (w_hit_now) begin
                r_hit_latch <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_btn_rise) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        if (r_hit_latch) begin
                            // A collision in this frame overrides any pending hop.
                            r_state     <= ST_DEAD;
                            r_collision <= 1'b1;
                            r_cnt       <= '0;
                            r_hop_pend  <= 1'b0;
                        end else begin
                            r_lane_x <= w_lane_x_next;
                            if (r_hop_pend) begin
                                r_y_offset <= w_y_offset_hop;
                                if (r_score < 7'(SCORE_MAX)) begin
                                    r_score <= r_score + 7'd1;
                                end
                            end
                            r_hop_pend <= w_btn_rise;
                        end
                    end else if (w_btn_rise) begin
                        r_hop_pend <= 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (frame_tick) begin
                        if (r_cnt == c_cnt_last) begin
                            r_state    <= ST_IDLE;
                            r_score    <= 7'd0;
                            r_y_offset <= 12'd0;
                            r_hop_pend <= 1'b0;
                            for (int i = 0; i < N_LANES; i++) begin
                                r_lane_x[i] <= f_x_init(i);
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rgb        = r_rgb;
    assign score      = r_score;
    assign game_state = r_state;
    assign collision  = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_crossy_lane_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossy_lane_engine
// Brief    : Randomised scoreboard bench for crossy_lane_engine against a
//            frame-level game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossy_lane_engine;

    localparam int N_LANES      = 3;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int OB_W         = 120;
    localparam int OB_H         = 70;
    localparam int LANE_PITCH   = 160;
    localparam int OB_X_SPACING = 200;
    localparam int HOP_PX       = 16;
    localparam int CHICKEN_X    = 310;
    localparam int CHICKEN_Y    = 420;
    localparam int CHICKEN_W    = 30;
    localparam int CHICKEN_H    = 40;
    localparam int BASE_SPEED   = 1;
    localparam int DEAD_FRAMES  = 60;
    localparam int SCORE_MAX    = 99;
    localparam int WRAP         = SCREEN_W + OB_W;
    localparam int SPAN         = N_LANES * LANE_PITCH;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_btn   = 1'b0;
    logic       video_on   = 1'b0;
    logic [9:0] pixel_x    = 10'd0;
    logic [9:0] pixel_y    = 10'd0;
    logic [2:0] rgb;
    logic [6:0] score;
    logic [1:0] game_state;
    logic       collision;

    crossy_lane_engine #(
        .N_LANES(N_LANES), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .OB_W(OB_W), .OB_H(OB_H), .LANE_PITCH(LANE_PITCH),
        .OB_X_SPACING(OB_X_SPACING), .HOP_PX(HOP_PX),
        .CHICKEN_X(CHICKEN_X), .CHICKEN_Y(CHICKEN_Y),
        .CHICKEN_W(CHICKEN_W), .CHICKEN_H(CHICKEN_H),
        .BASE_SPEED(BASE_SPEED), .DEAD_FRAMES(DEAD_FRAMES), .SCORE_MAX(SCORE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .move_btn(move_btn),
        .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .rgb(rgb), .score(score), .game_state(game_state), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rgb;
        int score;
        int st;
        int coll;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Game model: 0 idle, 1 play, 2 dead
    int m_state;
    int m_x[N_LANES];
    int m_yoff, m_score, m_pend, m_hit, m_cnt, m_b1, m_b2;
    int btn_level = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_new_game();
        m_score = 0;
        m_yoff  = 0;
        m_pend  = 0;
        for (int i = 0; i < N_LANES; i++) m_x[i] = (i * OB_X_SPACING) % WRAP;
    endtask

    task automatic model_step(input bit r, input bit t, input bit b, input bit v,
                              input int px, input int py);
        exp_t e;
        int   rise, ob, ch, vis, hit_now, old_hit, spd, ly;
        e = '{0, 0, 0, 0};
        if (!r) begin
            m_state = 0;
            model_new_game();
            m_hit = 0;
            m_cnt = 0;
            m_b1  = 0;
            m_b2  = 0;
        end else begin
            rise = (m_b1 == 1 && m_b2 == 0) ? 1 : 0;
            ob = 0;
            for (int i = 0; i < N_LANES; i++) begin
                ly = (i * LANE_PITCH + m_yoff) % SPAN;
                if (px >= m_x[i] - OB_W && px < m_x[i] &&
                    ly < SCREEN_H && py >= ly && py < ly + OB_H) ob = 1;
            end
            ch = (px >= CHICKEN_X && px < CHICKEN_X + CHICKEN_W &&
                  py >= CHICKEN_Y && py < CHICKEN_Y + CHICKEN_H) ? 1 : 0;
            vis = (m_state != 2 || ((m_cnt / 8) % 2) == 0) ? 1 : 0;
            if (!v)                 e.rgb = 0;
            else if (ob != 0)       e.rgb = 1;
            else if (ch && vis)     e.rgb = 2;
            else                    e.rgb = 4;
            hit_now = (m_state == 1 && v && ob && ch) ? 1 : 0;
            old_hit = m_hit;
            if (t) m_hit = 0;
            else if (hit_now != 0) m_hit = 1;
            case (m_state)
                0: if (rise != 0) m_state = 1;
                1: begin
                    if (t) begin
                        if (old_hit != 0) begin
                            m_state = 2;
                            e.coll  = 1;
                            m_cnt   = 0;
                            m_pend  = 0;
                        end else begin
                            spd = BASE_SPEED + m_score / 16;
                            for (int i = 0; i < N_LANES; i++) begin
                                if (i % 2 == 0) m_x[i] = (m_x[i] + spd) % WRAP;
                                else            m_x[i] = (m_x[i] - spd + WRAP) % WRAP;
                            end
                            if (m_pend != 0) begin
                                m_yoff = (m_yoff + HOP_PX) % SPAN;
                                if (m_score < SCORE_MAX) m_score++;
                            end
                            m_pend = rise;
                        end
                    end else if (rise != 0) begin
                        m_pend = 1;
                    end
                end
                default: begin
                    if (t) begin
                        if (m_cnt == DEAD_FRAMES - 1) begin
                            m_state = 0;
                            model_new_game();
                        end else begin
                            m_cnt++;
                        end
                    end
                end
            endcase
            m_b2 = m_b1;
            m_b1 = b;
        end
        e.score = m_score;
        e.st    = m_state;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit t, input bit b, input bit v,
                         input int px, input int py);
        @(negedge clk);
        rst_n      = r;
        frame_tick = t;
        move_btn   = b;
        video_on   = v;
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        model_step(r, t, b, v, px, py);
    endtask

    // pmode 0: anywhere, 1: biased onto the chicken, 2: never on the chicken
    task automatic pick_pixel(input int pmode, output bit v, output int px, output int py);
        v  = ($urandom_range(0, 9) != 0);
        px = $urandom_range(0, 799);
        py = $urandom_range(0, 524);
        if (pmode == 1 && $urandom_range(0, 1) == 1) begin
            v  = 1'b1;
            px = $urandom_range(295, 350);
            py = $urandom_range(405, 470);
        end
        if (pmode == 2 && px >= CHICKEN_X && px < CHICKEN_X + CHICKEN_W &&
            py >= CHICKEN_Y && py < CHICKEN_Y + CHICKEN_H) px = px + 40;
    endtask

    // bmode 0: released, 1: random toggling, 2: three presses, 3: held
    task automatic run_frame(input int len, input int bmode, input int pmode);
        bit v, b;
        int px, py;
        for (int c = 0; c < len; c++) begin
            case (bmode)
                0: b = 1'b0;
                1: begin
                    if ($urandom_range(0, 4) == 0) btn_level = 1 - btn_level;
                    b = (btn_level != 0);
                end
                2: b = (c == 1 || c == 3 || c == 5);
                default: b = 1'b1;
            endcase
            pick_pixel(pmode, v, px, py);
            if (c == len - 1) v = 1'b0;
            drive(1'b1, c == len - 1, b, v, px, py);
        end
    endtask

    task automatic start_game();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rgb", int'(rgb), e.rgb);
                chk("score", int'(score), e.score);
                chk("game_state", int'(game_state), e.st);
                chk("collision", int'(collision), e.coll);
            end
        end
    end

    initial begin : stimulus
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int f = 0; f < 10; f++) run_frame(16, 0, 0);
        start_game();
        run_frame(16, 3, 0);
        for (int f = 0; f < 250; f++) begin
            run_frame($urandom_range(10, 20), ($urandom_range(0, 3) == 0) ? 2 : 1, 1);
        end

        // Mid-game reset, then a collision-free climb to score saturation.
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        start_game();
        for (int f = 0; f < 120; f++) run_frame(16, 2, 2);
        @(posedge clk);
        #2;
        chk("score_saturated", int'(score), SCORE_MAX);
        for (int f = 0; f < 150; f++) run_frame(16, 0, 2);
        for (int f = 0; f < 150; f++) run_frame(14, 1, 1);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
